mmio_req_arbiter: RTL and testbench
===================================

MMIO_REQ_ARBITER -- requirements
Module: mmio_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; 2..8.
REQ-002 Parameter ADDR_W, default 32: MMIO byte-address width.
REQ-003 Parameter DATA_W, default 64: MMIO data width.
REQ-004 Parameter TIMEOUT_CYC, default 1024: maximum read-response wait in cycles; minimum 2.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid / req_ready  in / out  NUM_REQ  per-requester request handshake.
REQ-008 req_write  in  NUM_REQ  1 = write, 0 = read.
REQ-009 req_addr / req_wdata  in  NUM_REQ*ADDR_W / NUM_REQ*DATA_W  packed per-requester address and write data.
REQ-010 req_pf / req_vf / req_va  in  NUM_REQ*3 / NUM_REQ*11 / NUM_REQ  target PF, VF and VF-active per requester.
REQ-011 m_valid / m_ready  out / in  1  downstream request handshake.
REQ-012 m_write, m_addr, m_wdata, m_pf, m_vf, m_va  out  1, ADDR_W, DATA_W, 3, 11, 1  granted request fields.
REQ-013 m_rsp_valid / m_rsp_data  in  1 / DATA_W  downstream read completion.
REQ-014 rsp_valid  out  NUM_REQ  one-hot read-response strobe.
REQ-015 rsp_data / rsp_err  out  DATA_W / 1  shared read data and timeout flag, valid while rsp_valid is nonzero.

Function
REQ-016 FSM states are IDLE, ISSUE, WAIT_RSP and RESP; only one transaction is outstanding at any time.
REQ-017 In IDLE with any req_valid set, the round-robin arbiter grants one requester, latches all of that requester's fields into holding registers, pulses its req_ready for exactly one cycle, and moves to ISSUE on the next cycle.
REQ-018 Round-robin: the search starts at the index one above the last grant and wraps modulo NUM_REQ; after reset the search starts at index 0.
REQ-019 In ISSUE, m_valid = 1 and m_* are driven from the holding registers, held stable until m_valid && m_ready.
REQ-020 Write handshake in ISSUE leads to IDLE, with no rsp_valid (writes are posted).
REQ-021 Read handshake in ISSUE leads to WAIT_RSP and clears the timeout counter.
REQ-022 WAIT_RSP: on m_rsp_valid, capture m_rsp_data and clear the error flag, then go to RESP; otherwise the counter increments, and when it reaches TIMEOUT_CYC-1 the block captures all-ones data, sets the error flag and goes to RESP.
REQ-023 Simultaneous m_rsp_valid and timeout terminal count: the response wins and rsp_err = 0.
REQ-024 RESP: for one cycle, drive rsp_valid[granted] = 1 with rsp_data and rsp_err, then go to IDLE.
REQ-025 m_rsp_valid arriving outside WAIT_RSP is ignored.
REQ-026 Request-to-downstream latency is 2 cycles (req_ready cycle, then m_valid); a zero-wait read response gives rsp_valid 1 cycle after m_rsp_valid.
REQ-027 req_ready is never asserted to more than one requester, and never outside IDLE.

Reset
REQ-028 rst forces IDLE, the round-robin pointer to 0, the timeout counter to 0, and req_ready, m_valid, rsp_valid and rsp_err to 0.
REQ-029 Reset mid-transaction abandons it: no rsp_valid is produced, and a late m_rsp_valid is ignored.
REQ-030 All other holding registers need no reset.

Structure
REQ-031 Package mmio_arb_pkg holds the state enum, PF_W = 3, VF_W = 11 and the all-ones error data constant.
REQ-032 Sub-module rr_arbiter (NUM_REQ-wide request vector in, one-hot grant out, pointer update on grant) is instantiated once.

Verification
REQ-033 Requester 0 writes 0x18 with data 0x0123_4567_89AB_CDEF, PF0/VF0/VA0, m_ready tied 1 -> m_valid occurs 2 cycles after req_valid with matching fields, and no rsp_valid follows.
REQ-034 Requester 2 reads 0x20018 targeting PF3; m_rsp_valid is driven 5 cycles after the handshake with 0xDEAD_BEEF -> rsp_valid = 4'b0100 with data 0xDEAD_BEEF and rsp_err = 0.
REQ-035 All 4 requesters hold req_valid for reads -> grants occur in order 0,1,2,3,0, and each gets exactly one response.
REQ-036 Read with no m_rsp_valid and TIMEOUT_CYC = 16 -> rsp_valid occurs after 16 wait cycles with data all-ones and rsp_err = 1.
REQ-037 m_rsp_valid arrives on the timeout terminal cycle -> the real data is returned with rsp_err = 0.
REQ-038 rst is asserted during WAIT_RSP and a late m_rsp_valid follows -> all outputs are 0, no rsp_valid appears, and the next grant goes to requester 0.

Source files
------------

// File: rtl/mmio_req_arbiter_pkg.sv
// Shared constants for the MMIO request arbiter: FSM state encodings,
// PF/VF field widths and the data pattern returned on a read timeout.
package mmio_arb_pkg;

  localparam int PF_W = 3;
  localparam int VF_W = 11;

  // Wide enough for any supported DATA_W; users slice the low bits.
  localparam int ERR_DATA_W = 256;
  localparam logic [ERR_DATA_W-1:0] ERR_DATA = '1;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t S_IDLE     = 2'd0;
  localparam arb_state_t S_ISSUE    = 2'd1;
  localparam arb_state_t S_WAIT_RSP = 2'd2;
  localparam arb_state_t S_RESP     = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the slot after the
// last accepted grant; the pointer only moves when the grant is taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 update,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          found;

  // Walk from the farthest candidate down so the nearest one wins last.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant = found ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mmio_req_arbiter.sv
// Arbitrates NUM_REQ MMIO requesters onto one downstream port with a single
// outstanding transaction; reads get a response or a timeout error.
module mmio_req_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*PF_W-1:0]   req_pf,
  input  logic [NUM_REQ*VF_W-1:0]   req_vf,
  input  logic [NUM_REQ-1:0]        req_va,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [PF_W-1:0]           m_pf,
  output logic [VF_W-1:0]           m_vf,
  output logic                      m_va,
  input  logic                      m_rsp_valid,
  input  logic [DATA_W-1:0]         m_rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t          state;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_take;
  logic [CNT_W-1:0]    cnt;
  logic                err_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                hold_write;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_wdata;
  logic [PF_W-1:0]     hold_pf;
  logic [VF_W-1:0]     hold_vf;
  logic                hold_va;
  logic                is_issue;
  logic                is_resp;

  // A grant is taken only once per IDLE visit; the req_ready cycle blocks a regrant.
  assign arb_take = (state == S_IDLE) && (req_ready == '0) && (|req_valid);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .update    (arb_take),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= '0;
      gnt_q     <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ready != '0) begin
            req_ready <= '0;
            state     <= S_ISSUE;
          end else if (arb_take) begin
            req_ready <= arb_grant;
            gnt_q     <= arb_grant;
          end
        end
        S_ISSUE: begin
          if (m_ready) begin
            state <= hold_write ? S_IDLE : S_WAIT_RSP;
            cnt   <= '0;
          end
        end
        S_WAIT_RSP: begin
          if (m_rsp_valid) begin
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (cnt == CNT_TERM) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arb_take) begin
      hold_write <= req_write[arb_idx];
      hold_addr  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
      hold_wdata <= req_wdata[arb_idx*DATA_W +: DATA_W];
      hold_pf    <= req_pf[arb_idx*PF_W +: PF_W];
      hold_vf    <= req_vf[arb_idx*VF_W +: VF_W];
      hold_va    <= req_va[arb_idx];
    end
    if (state == S_WAIT_RSP) begin
      if (m_rsp_valid) begin
        rsp_data_q <= m_rsp_data;
      end else if (cnt == CNT_TERM) begin
        rsp_data_q <= ERR_DATA[DATA_W-1:0];
      end
    end
  end

  // Outputs are gated so that nothing stale leaks out of the holding registers.
  assign is_issue  = (state == S_ISSUE);
  assign is_resp   = (state == S_RESP);
  assign m_valid   = is_issue;
  assign m_write   = is_issue & hold_write;
  assign m_addr    = is_issue ? hold_addr  : '0;
  assign m_wdata   = is_issue ? hold_wdata : '0;
  assign m_pf      = is_issue ? hold_pf    : '0;
  assign m_vf      = is_issue ? hold_vf    : '0;
  assign m_va      = is_issue & hold_va;
  assign rsp_valid = is_resp ? gnt_q      : '0;
  assign rsp_data  = is_resp ? rsp_data_q : '0;
  assign rsp_err   = is_resp & err_q;

endmodule

// File: tb/tb_mmio_req_arbiter.sv
// Directed bench for mmio_req_arbiter: write, read, round-robin, timeout,
// response/timeout collision and mid-transaction reset.
module tb_mmio_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write, req_va;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*3-1:0]  req_pf;
  logic [N*11-1:0] req_vf;
  logic            m_valid, m_ready, m_write, m_va;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [2:0]      m_pf;
  logic [10:0]     m_vf;
  logic            m_rsp_valid;
  logic [DW-1:0]   m_rsp_data;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  int checks = 0;
  int errors = 0;

  mmio_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pf(req_pf),
    .req_vf(req_vf), .req_va(req_va),
    .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_pf(m_pf), .m_vf(m_vf), .m_va(m_va),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] pf,
                         input logic [10:0] vf, input logic va);
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_pf[i*3 +: 3]       = pf;
    req_vf[i*11 +: 11]     = vf;
    req_va[i]              = va;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_pf = '0; req_vf = '0; req_va = '0;
    m_ready = 1'b1; m_rsp_valid = 1'b0; m_rsp_data = '0;
    tick(); tick(); tick();
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int seen;
    set_req(0, 1'b1, 32'h18, 64'h0123_4567_89AB_CDEF, 3'd0, 11'd0, 1'b0);
    req_valid = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_req_ready got %b want 0001", req_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL wr_m_valid_early got %b want 0", m_valid); end
    req_valid = '0;
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL wr_m_valid got %b want 1", m_valid); end
    checks++; if ({m_write, m_addr, m_wdata, m_pf, m_vf, m_va} !== {1'b1, 32'h18, 64'h0123_4567_89AB_CDEF, 3'd0, 11'd0, 1'b0}) begin
      errors++; $display("FAIL wr_fields got w=%b a=%h d=%h pf=%0d vf=%0d va=%b", m_write, m_addr, m_wdata, m_pf, m_vf, m_va);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) m_rsp_valid = 1'b1;
      tick();
      m_rsp_valid = 1'b0;
      if (rsp_valid !== 4'b0 || req_ready !== 4'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL wr_no_rsp got %0d active cycles want 0", seen); end
  endtask

  task automatic test_read();
    set_req(2, 1'b0, 32'h0002_0018, 64'h0, 3'd3, 11'd5, 1'b1);
    req_valid = 4'b0100;
    m_ready = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rd_req_ready got %b want 0100", req_ready); end
    req_valid = '0;
    tick();
    tick();
    checks++; if ({m_valid, m_write, m_addr, m_pf, m_vf, m_va} !== {1'b1, 1'b0, 32'h0002_0018, 3'd3, 11'd5, 1'b1}) begin
      errors++; $display("FAIL rd_stall_fields got v=%b w=%b a=%h pf=%0d vf=%0d va=%b", m_valid, m_write, m_addr, m_pf, m_vf, m_va);
    end
    m_ready = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) tick();
    checks++; if (rsp_valid !== 4'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_quiet got rsp=%b mv=%b want 0000/0", rsp_valid, m_valid); end
    m_rsp_valid = 1'b1;
    m_rsp_data = 64'hDEAD_BEEF;
    tick();
    m_rsp_valid = 1'b0;
    m_rsp_data = '0;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL rd_rsp_valid got %b want 0100", rsp_valid); end
    checks++; if (rsp_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_data got %h want deadbeef", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err got %b want 0", rsp_err); end
    tick();
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rd_rsp_one_cycle got %b want 0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] gseq [5];
    logic [N-1:0] exp_g [5];
    logic [N-1:0] last;
    int ng, nrsp, badrsp, multi;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    ng = 0; nrsp = 0; badrsp = 0; multi = 0; last = '0;
    for (int k = 0; k < 5; k++) gseq[k] = '0;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 + 32'(i), 64'h0, 3'd0, 11'd0, 1'b0);
    m_rsp_valid = 1'b1;
    m_rsp_data = 64'h55;
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && nrsp < 5; c++) begin
      tick();
      if (req_ready !== 4'b0) begin
        if (!$onehot(req_ready)) multi++;
        if (ng < 5) gseq[ng] = req_ready;
        ng++;
        last = req_ready;
      end
      if (rsp_valid !== 4'b0) begin
        if (rsp_valid !== last) badrsp++;
        nrsp++;
      end
    end
    req_valid = '0;
    m_rsp_valid = 1'b0;
    checks++; if (nrsp !== 5) begin errors++; $display("FAIL rr_rsp_count got %0d want 5", nrsp); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (gseq[k] !== exp_g[k]) begin errors++; $display("FAIL rr_grant_%0d got %b want %b", k, gseq[k], exp_g[k]); end
    end
    checks++; if (badrsp !== 0) begin errors++; $display("FAIL rr_rsp_owner got %0d wrong want 0", badrsp); end
    checks++; if (multi !== 0) begin errors++; $display("FAIL rr_ready_onehot got %0d multi want 0", multi); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    set_req(1, 1'b0, 32'h40, 64'h0, 3'd1, 11'd2, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL to_m_valid got %b want 1", m_valid); end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid !== 4'b0) break;
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_wait_cycles got %0d want 16", n); end
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL to_rsp_valid got %b want 0010", rsp_valid); end
    checks++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL to_rsp_data got %h want all ones", rsp_data); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp_err got %b want 1", rsp_err); end
    tick();
  endtask

  task automatic test_collision();
    set_req(3, 1'b0, 32'h80, 64'h0, 3'd2, 11'd7, 1'b0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < 16; c++) tick();
    m_rsp_valid = 1'b1;
    m_rsp_data = 64'h1234_5678;
    tick();
    m_rsp_valid = 1'b0;
    m_rsp_data = '0;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL col_rsp_valid got %b want 1000", rsp_valid); end
    checks++; if (rsp_data !== 64'h1234_5678) begin errors++; $display("FAIL col_rsp_data got %h want 12345678", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL col_rsp_err got %b want 0", rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    set_req(2, 1'b0, 32'h0002_0018, 64'h0, 3'd3, 11'd0, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({req_ready, m_valid, m_addr, rsp_valid, rsp_data, rsp_err} !== '0) begin
      errors++; $display("FAIL rm_outputs got rdy=%b mv=%b a=%h rv=%b rd=%h re=%b want all 0", req_ready, m_valid, m_addr, rsp_valid, rsp_data, rsp_err);
    end
    m_rsp_valid = 1'b1;
    m_rsp_data = 64'hBAD;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      m_rsp_valid = 1'b0;
      if (rsp_valid !== 4'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_late_rsp got %0d rsp cycles want 0", seen); end
    set_req(0, 1'b0, 32'h8, 64'h0, 3'd0, 11'd0, 1'b0);
    set_req(3, 1'b0, 32'hC, 64'h0, 3'd0, 11'd0, 1'b0);
    req_valid = 4'b1001;
    tick();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_next_grant got %b want 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
